// File: rtl/mem_responder.sv
// mem_responder: word-wide memory target for the multicycle CPU's unified
// instruction/data port. One request at a time, WAIT_CYCLES wait states,
// one-cycle ready pulse, error response for misaligned/out-of-range access.
// Optional byte-enable writes: define MEM_RESPONDER_BYTE_EN.
module mem_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
`ifdef MEM_RESPONDER_BYTE_EN
  input  logic [3:0]  be,
`endif
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  // Counter preload; WAIT_CYCLES=0 never enters WAIT so the value is moot.
  localparam int WLOAD = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_ERR} state_t;

  // Transaction latched at acceptance.
  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] idx;
    logic [31:0]           wdata;
    logic [3:0]            be;
  } req_t;

  state_t                state, nstate;
  req_t                  rq;
  logic [3:0]            cnt;
  logic [31:0]           mem [DEPTH];
  logic                  bad;
  logic                  rd_we;
  logic [ADDR_WIDTH-1:0] rd_idx;
  logic [3:0]            be_in;

`ifdef MEM_RESPONDER_BYTE_EN
  assign be_in = be;
`else
  assign be_in = 4'hF;
`endif

  // Misaligned or beyond the array: any set bit above the word index.
  assign bad = (addr[1:0] != 2'b00) || (|addr[31:ADDR_WIDTH+2]);

  // With zero wait states the read happens on the acceptance edge itself,
  // before the request is latched, so select the live inputs in IDLE.
  assign rd_idx = (state == S_IDLE) ? addr[ADDR_WIDTH+1:2] : rq.idx;
  assign rd_we  = (state == S_IDLE) ? we : rq.we;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= nstate;
  end

  // Next-state logic.
  always_comb begin
    nstate = state;
    case (state)
      S_IDLE: if (req) begin
        if (bad)                   nstate = S_ERR;
        else if (WAIT_CYCLES == 0) nstate = S_RESP;
        else                       nstate = S_WAIT;
      end
      S_WAIT: if (cnt == 4'd0) nstate = S_RESP;
      S_RESP: nstate = S_IDLE;
      S_ERR:  nstate = S_IDLE;
      default: nstate = S_IDLE;
    endcase
  end

  // Request latch, wait counter and registered response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      ready <= 1'b0;
      err   <= 1'b0;
      rdata <= 32'd0;
      cnt   <= 4'd0;
      rq    <= '0;
    end else begin
      ready <= (nstate == S_RESP) || (nstate == S_ERR);
      err   <= (nstate == S_ERR);
      if (state == S_IDLE && req) begin
        rq.we    <= we;
        rq.idx   <= addr[ADDR_WIDTH+1:2];
        rq.wdata <= wdata;
        rq.be    <= be_in;
        cnt      <= 4'(WLOAD);
      end else if (state == S_WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      // Reads load rdata on the edge entering RESP; writes leave it alone.
      if (nstate == S_RESP && !rd_we)
        rdata <= mem[rd_idx];
    end
  end

  // Array write on the edge leaving RESP; a reset on that edge aborts it.
  always_ff @(posedge clk) begin
    if (!rst && state == S_RESP && rq.we) begin
      for (int b = 0; b < 4; b++)
        if (rq.be[b]) mem[rq.idx][8*b +: 8] <= rq.wdata[8*b +: 8];
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Randomized self-checking bench for mem_responder against a
// transaction-level model (word array + per-byte "known" mask).
module tb_mem_responder;
  localparam int AW = 10;
  localparam int W  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        we  = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
`ifdef MEM_RESPONDER_BYTE_EN
  logic [3:0]  be = 4'hF;
`endif
  logic [31:0] rdata;
  logic        ready;
  logic        err;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state.
  logic [31:0] m_word  [2**AW];
  logic [3:0]  m_known [2**AW];
  logic [31:0] exp_rd;
  bit          exp_known;

  mem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
`ifdef MEM_RESPONDER_BYTE_EN
    .be(be),
`endif
    .rdata(rdata), .ready(ready), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; req = 1'b0;
    @(posedge clk); @(posedge clk);
    @(negedge clk); rst = 1'b0;
    chk("rst_ready", ready, 0);
    chk("rst_err", err, 0);
    chk("rst_rdata", rdata, 0);
    exp_rd = 32'd0; exp_known = 1'b1;
  endtask

  // One complete transaction; checks latency, err, rdata and the model.
  task automatic run_txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] b);
    bit e;
    int cycles;
    int idx;
    e = (a[1:0] != 2'b00) || ((a >> (AW + 2)) != 0);
    idx = int'((a >> 2) % (2**AW));
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d;
`ifdef MEM_RESPONDER_BYTE_EN
    be = b;
`endif
    @(posedge clk);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!ready && cycles < 50);
    req = 1'b0;
    chk("latency", cycles, e ? 1 : W + 1);
    chk("err", err, e);
    if (!e && !w) begin
      exp_known = (m_known[idx] == 4'hF);
      exp_rd    = m_word[idx];
    end
    if (exp_known) chk("rdata", rdata, exp_rd);
    if (!e && w) begin
`ifdef MEM_RESPONDER_BYTE_EN
      for (int k = 0; k < 4; k++)
        if (b[k]) begin
          m_word[idx][8*k +: 8] = d[8*k +: 8];
          m_known[idx][k] = 1'b1;
        end
`else
      if (b != 4'h0) begin
        m_word[idx]  = d;
        m_known[idx] = 4'hF;
      end
`endif
    end
    @(negedge clk);
    chk("ready_drop", ready, 0);
  endtask

  initial begin
    int p1, p2, pulses, t;
    for (int i = 0; i < 2**AW; i++) begin
      m_word[i] = '0; m_known[i] = 4'h0;
    end
    exp_rd = '0; exp_known = 1'b0;

    do_reset();

    // Basic write/read, misaligned read, re-read.
    run_txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    run_txn(1'b0, 32'h10, 32'h0, 4'hF);
    chk("raw_value", rdata, 32'hDEADBEEF);
    run_txn(1'b0, 32'h13, 32'h0, 4'hF);
    run_txn(1'b0, 32'h10, 32'h0, 4'hF);

    // Out-of-range write must not alias onto word 0.
    run_txn(1'b1, 32'h0, 32'h0BADF00D, 4'hF);
    run_txn(1'b1, 32'h4, 32'h44444444, 4'hF);
    run_txn(1'b1, 32'h1000, 32'h12345678, 4'hF);
    run_txn(1'b0, 32'h0, 32'h0, 4'hF);
    chk("oor_untouched", rdata, 32'h0BADF00D);

    // req held high across two reads: two pulses W+2 apart.
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 32'h0;
`ifdef MEM_RESPONDER_BYTE_EN
    be = 4'hF;
`endif
    p1 = 0; p2 = 0; pulses = 0; t = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      t++;
      if (ready) begin
        pulses++;
        if (pulses == 1) begin
          p1 = t; chk("b2b_rd0", rdata, m_word[0]); addr = 32'h4;
        end else if (pulses == 2) begin
          p2 = t; chk("b2b_rd1", rdata, m_word[1]); req = 1'b0;
        end
      end
    end
    req = 1'b0;
    chk("b2b_pulses", pulses, 2);
    chk("b2b_first", p1, W + 1);
    chk("b2b_gap", p2 - p1, W + 2);
    exp_rd = m_word[1]; exp_known = 1'b1;

    // Reset during WAIT aborts the write.
    run_txn(1'b1, 32'h20, 32'hCAFE0001, 4'hF);
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'hFFFF0000;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1; req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_rd = 32'd0; exp_known = 1'b1;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (ready) pulses++;
    end
    chk("abort_ready", pulses, 0);
    run_txn(1'b0, 32'h20, 32'h0, 4'hF);
    chk("abort_value", rdata, 32'hCAFE0001);

`ifdef MEM_RESPONDER_BYTE_EN
    run_txn(1'b1, 32'h8, 32'h11223344, 4'hF);
    run_txn(1'b1, 32'h8, 32'hAABBCCDD, 4'b0101);
    run_txn(1'b1, 32'h8, 32'h99999999, 4'b0000);
    run_txn(1'b0, 32'h8, 32'h0, 4'hF);
    chk("be_merge", rdata, 32'h11BB33DD);
`endif

    // Randomized traffic over a small window plus error cases.
    for (int i = 0; i < 150; i++) begin
      int sel;
      logic [31:0] a;
      logic [3:0]  b;
      sel = $urandom_range(0, 9);
      if (sel == 0)      a = {26'($urandom_range(0, 15)), 4'(0), 2'($urandom_range(1, 3))};
      else if (sel == 1) a = 32'h1000 + 32'({$urandom_range(0, 255), 2'b00});
      else               a = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
`ifdef MEM_RESPONDER_BYTE_EN
      b = 4'($urandom_range(0, 15));
`else
      b = 4'hF;
`endif
      run_txn(1'($urandom_range(0, 1)), a, $urandom, b);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
